bs_lut_wb_packer: RTL and testbench

BS_LUT_WB_PACKER -- requirements
Module: bs_lut_wb_packer

---
 rtl/bs_lut_wb_packer.sv | 81 ++++++++
 tb/tb_bs_lut_wb_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bs_lut_wb_packer.sv
// bs_lut_wb_packer: drains tile_len output-buffer rows (rd_en/rd_addr/rd_sel/rd_data) into AXIS_DW beats on m_axis_*, start/busy/done control
module bs_lut_wb_packer #(
  parameter int BS_COLS = 36,
  parameter int PSU_DW = 8,
  parameter int AXIS_DW = 64,
  parameter int BS_OUT_BUF_DEPTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [BS_OUT_BUF_DEPTH:0] tile_len,
  input  logic buf_sel_in,
  output logic busy,
  output logic done,
  output logic rd_en,
  output logic [BS_OUT_BUF_DEPTH-1:0] rd_addr,
  output logic rd_sel,
  input  logic [BS_COLS*PSU_DW-1:0] rd_data,
  output logic [AXIS_DW-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic m_axis_tlast
);
  localparam int LPB = AXIS_DW / PSU_DW;
  localparam int NGRP = (BS_COLS + LPB - 1) / LPB;
  localparam int GW = NGRP > 1 ? $clog2(NGRP) : 1;
  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, DONE} state_t;
  state_t state;
  logic [BS_OUT_BUF_DEPTH:0] len, addr;
  logic [GW-1:0] grp;
  logic sel;
  logic [NGRP*AXIS_DW-1:0] row;
  logic last_grp, last_addr;
  assign last_grp = grp == GW'(NGRP - 1);
  assign last_addr = addr + 1'b1 == len;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      addr <= '0;
      grp <= '0;
      sel <= 1'b0;
      row <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (tile_len != '0) begin
            len <= tile_len;
            sel <= buf_sel_in;
            addr <= '0;
            grp <= '0;
            state <= RD;
          end else state <= DONE;
        end
        RD: state <= WAIT;
        WAIT: begin
          row <= (NGRP*AXIS_DW)'(rd_data);
          state <= SEND;
        end
        SEND: if (m_axis_tready) begin
          if (!last_grp) grp <= grp + 1'b1;
          else if (!last_addr) begin
            addr <= addr + 1'b1;
            grp <= '0;
            state <= RD;
          end else state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rd_en = state == RD;
  assign rd_addr = addr[BS_OUT_BUF_DEPTH-1:0];
  assign rd_sel = sel;
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tlast = m_axis_tvalid && last_grp && last_addr;
  assign m_axis_tdata = row[AXIS_DW*grp +: AXIS_DW];
endmodule

// File: tb/tb_bs_lut_wb_packer.sv
// tb_bs_lut_wb_packer: randomized self-checking bench for bs_lut_wb_packer against a lane-level beat model
module tb_bs_lut_wb_packer;
  localparam int BS_COLS = 36;
  localparam int PSU_DW = 8;
  localparam int AXIS_DW = 64;
  localparam int D = 4;
  localparam int LPB = AXIS_DW / PSU_DW;
  localparam int NGRP = (BS_COLS + LPB - 1) / LPB;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [D:0] tile_len = '0;
  logic buf_sel_in = 0;
  logic busy, done, rd_en, rd_sel, tvalid, tlast;
  logic tready;
  logic [D-1:0] rd_addr;
  logic [BS_COLS*PSU_DW-1:0] rd_data, rd_tmp;
  logic [AXIS_DW-1:0] tdata;
  bs_lut_wb_packer #(.BS_COLS(BS_COLS), .PSU_DW(PSU_DW), .AXIS_DW(AXIS_DW), .BS_OUT_BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len), .buf_sel_in(buf_sel_in),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
  );
  always #5 clk = ~clk;
  typedef struct {logic [AXIS_DW-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  int exp_addr[$];
  logic [AXIS_DW-1:0] got_q[$];
  logic [PSU_DW-1:0] mem [2][1<<D][BS_COLS];
  int n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0, done_cyc = 0, tr_mode = 0;
  logic cur_sel = 0, expect_done = 0, seen_done = 0;
  logic held_v = 0, held_l = 0;
  logic [AXIS_DW-1:0] held_d = '0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    for (int k = 0; k < BS_COLS; k++)
      rd_tmp[k*PSU_DW +: PSU_DW] = rd_en ? mem[rd_sel][rd_addr][k] : PSU_DW'($urandom);
    rd_data <= rd_tmp;
  end
  initial begin
    tready = 1;
    forever begin
      @(posedge clk);
      #1;
      tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? 1'($urandom % 2) : ~tready;
    end
  end
  always @(negedge clk) if (!rst) begin
    beat_t b;
    if (held_v) begin
      check("stall_valid", tvalid, 1);
      check("stall_data", tdata, held_d);
      check("stall_last", tlast, held_l);
    end
    held_v = tvalid && !tready;
    held_d = tdata;
    held_l = tlast;
    if (rd_en) begin
      if (exp_addr.size() == 0) check("rd_spurious", rd_en, 0);
      else begin
        check("rd_addr", rd_addr, exp_addr.pop_front());
        check("rd_sel", rd_sel, cur_sel);
      end
    end
    if (tvalid && tready) begin
      got_q.push_back(tdata);
      if (exp_q.size() == 0) check("beat_spurious", tvalid, 0);
      else begin
        b = exp_q.pop_front();
        check("tdata", tdata, b.d);
        check("tlast", tlast, b.l);
        if (b.l) last_cyc = cyc;
      end
    end
    if (done) begin
      check("done_expected", expect_done, 1);
      check("done_lat", cyc, last_cyc + 1);
      check("done_pending", exp_q.size(), 0);
      seen_done = 1;
      expect_done = 0;
      done_cyc = cyc;
    end
  end
  task automatic start_tile(input int len, input logic sel, input bit fill, output int sc);
    @(posedge clk);
    #1;
    for (int a = 0; a < len; a++) begin
      if (fill) for (int k = 0; k < BS_COLS; k++) mem[sel][a][k] = PSU_DW'($urandom);
      exp_addr.push_back(a);
      for (int g = 0; g < NGRP; g++) begin
        beat_t b;
        b.d = '0;
        for (int i = 0; i < LPB; i++)
          if (g*LPB + i < BS_COLS) b.d[i*PSU_DW +: PSU_DW] = mem[sel][a][g*LPB + i];
        b.l = (a == len - 1) && (g == NGRP - 1);
        exp_q.push_back(b);
      end
    end
    cur_sel = sel;
    expect_done = 1;
    seen_done = 0;
    got_q.delete();
    last_cyc = cyc;
    sc = cyc;
    start = 1;
    tile_len = (D+1)'(len);
    buf_sel_in = sel;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic finish_tile(input int len, input int mode, input int sc);
    for (int i = 0; i < 3000 && !seen_done; i++) @(negedge clk);
    check("done_seen", seen_done, 1);
    check("q_empty", exp_q.size(), 0);
    check("addr_empty", exp_addr.size(), 0);
    if (mode == 0) check("throughput", done_cyc - sc, len*(NGRP + 2) + 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask
  task automatic run_tile(input int len, input logic sel, input int mode, input bit poke, input bit fill);
    int sc;
    tr_mode = mode;
    start_tile(len, sel, fill, sc);
    @(negedge clk);
    if (len == 0) begin
      check("z_done", done, 1);
      check("z_rd_en", rd_en, 0);
      check("z_tvalid", tvalid, 0);
    end else begin
      check("lat_rd_en", rd_en, 1);
      check("lat_busy", busy, 1);
      check("lat_tvalid_rd", tvalid, 0);
      @(negedge clk);
      check("lat_tvalid_wait", tvalid, 0);
      check("lat_rd_en_wait", rd_en, 0);
      @(negedge clk);
      check("lat_tvalid_send", tvalid, 1);
      if (poke) begin
        @(posedge clk);
        #1;
        start = 1;
        tile_len = 5'd7;
        buf_sel_in = ~sel;
        @(posedge clk);
        #1;
        start = 0;
      end
    end
    finish_tile(len, mode, sc);
  endtask
  initial begin
    int sc;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_sel", rd_sel, 0);
    check("rst_tdata", tdata, 0);
    rst = 0;
    for (int k = 0; k < BS_COLS; k++) mem[0][0][k] = PSU_DW'(k + 1);
    run_tile(1, 0, 0, 0, 0);
    check("beat_count", got_q.size(), NGRP);
    if (got_q.size() == NGRP) begin
      check("beat0_const", got_q[0], 64'h0807060504030201);
      check("beat4_const", got_q[4], 64'h0000000024232221);
    end
    run_tile(3, 1, 2, 1, 1);
    check("beat_count3", got_q.size(), 3*NGRP);
    run_tile(0, 0, 0, 0, 1);
    for (int t = 0; t < 6; t++) begin
      int len = 1 + int'($urandom_range(0, 4));
      run_tile(len, 1'($urandom % 2), t % 2, len > 1, 1);
    end
    run_tile(1 << D, 0, 0, 0, 1);
    check("full_count", got_q.size(), (1 << D)*NGRP);
    begin
      int sc;
      tr_mode = 0;
      start_tile(4, 0, 1, sc);
      for (int i = 0; i < 200 && !(tvalid && rd_addr == 2); i++) @(negedge clk);
      check("abort_reach", rd_addr, 2);
      @(posedge clk);
      #1;
      rst = 1;
      expect_done = 0;
      @(posedge clk);
      #1;
      rst = 0;
      exp_q.delete();
      exp_addr.delete();
      @(negedge clk);
      check("abort_tvalid", tvalid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_rd_addr", rd_addr, 0);
      repeat (3) @(negedge clk);
      check("abort_no_done", done, 0);
    end
    run_tile(2, 1, 1, 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
